change_dispenser: RTL and testbench

Pays out the change amount produced by the vending datapath as physical coins. Accepts an 8-bit change value on a start pulse, chooses coins greedily (largest denomination first) from an internal per-denomination inventory, and drives a coin hopper through a req/ack handshake, one coin per handshake. It sits between the datapath's change output and the hopper. It reports completion, amount paid, and any shortfall when inventory cannot cover the request.

---
 rtl/vend_pkg.sv | 27 ++
 rtl/coin_inventory.sv | 56 +++++
 rtl/change_dispenser.sv | 125 ++++++++++++
 tb/tb_change_dispenser.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending definitions: coin_sel encodings, denomination values and dispenser states.
package vend_pkg;

  localparam logic [1:0] COIN_1 = 2'd0;
  localparam logic [1:0] COIN_2 = 2'd1;
  localparam logic [1:0] COIN_5 = 2'd2;

  localparam logic [7:0] VAL_1 = 8'd1;
  localparam logic [7:0] VAL_2 = 8'd2;
  localparam logic [7:0] VAL_5 = 8'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_REQ,
    ST_DONE
  } disp_state_t;

  function automatic logic [7:0] coin_value(input logic [1:0] sel);
    case (sel)
      COIN_5:  return VAL_5;
      COIN_2:  return VAL_2;
      default: return VAL_1;
    endcase
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// Per-denomination coin counters: saturating restock, guarded single-coin decrement.
module coin_inventory
  import vend_pkg::*;
#(
  parameter int INV_W     = 8,
  parameter int INIT_CNT5 = 20,
  parameter int INIT_CNT2 = 20,
  parameter int INIT_CNT1 = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_restock,
  input  logic [1:0]       i_restock_sel,
  input  logic [INV_W-1:0] i_restock_cnt,
  input  logic             i_dec,
  input  logic [1:0]       i_dec_sel,
  output logic [INV_W-1:0] o_cnt5,
  output logic [INV_W-1:0] o_cnt2,
  output logic [INV_W-1:0] o_cnt1
);

  localparam logic [INV_W-1:0] ONE = {{(INV_W-1){1'b0}}, 1'b1};
  localparam logic [INV_W-1:0] RST5 = INV_W'(INIT_CNT5);
  localparam logic [INV_W-1:0] RST2 = INV_W'(INIT_CNT2);
  localparam logic [INV_W-1:0] RST1 = INV_W'(INIT_CNT1);

  // Indexed by coin_sel encoding: [0]=1-unit, [1]=2-unit, [2]=5-unit
  logic [INV_W-1:0] r_cnt [3];

  function automatic logic [INV_W-1:0] sat_add(input logic [INV_W-1:0] a,
                                               input logic [INV_W-1:0] b);
    logic [INV_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[INV_W] ? {INV_W{1'b1}} : sum[INV_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt[0] <= RST1;
      r_cnt[1] <= RST2;
      r_cnt[2] <= RST5;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (i_restock && i_restock_sel == 2'(i))
          r_cnt[i] <= sat_add(r_cnt[i], i_restock_cnt);
        else if (i_dec && i_dec_sel == 2'(i) && r_cnt[i] != '0)
          r_cnt[i] <= r_cnt[i] - ONE;
      end
    end
  end

  assign o_cnt1 = r_cnt[0];
  assign o_cnt2 = r_cnt[1];
  assign o_cnt5 = r_cnt[2];

endmodule

// File: rtl/change_dispenser.sv
// Greedy change payout: picks the largest affordable coin in stock and
// hands it to the hopper over a req/ack handshake, one coin at a time.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int INV_W     = 8,
  parameter int INIT_CNT5 = 20,
  parameter int INIT_CNT2 = 20,
  parameter int INIT_CNT1 = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       amount,
  output logic             coin_req,
  output logic [1:0]       coin_sel,
  input  logic             coin_ack,
  input  logic             restock,
  input  logic [1:0]       restock_sel,
  input  logic [INV_W-1:0] restock_cnt,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [7:0]       remaining,
  output logic [7:0]       paid,
  output logic [INV_W-1:0] cnt5,
  output logic [INV_W-1:0] cnt2,
  output logic [INV_W-1:0] cnt1
);

  disp_state_t r_state, w_next;
  logic [7:0]  r_remaining;
  logic [7:0]  r_paid;
  logic [1:0]  r_coin_sel;
  logic        w_sel_ok;
  logic [1:0]  w_sel;
  logic        w_start_ok;
  logic        w_restock_ok;
  logic        w_ack;
  logic [7:0]  w_value;

  assign w_start_ok   = (r_state == ST_IDLE) && start;
  assign w_restock_ok = (r_state == ST_IDLE) && restock;
  assign w_ack        = (r_state == ST_REQ) && coin_ack;
  assign w_value      = coin_value(r_coin_sel);

  coin_inventory #(
    .INV_W    (INV_W),
    .INIT_CNT5(INIT_CNT5),
    .INIT_CNT2(INIT_CNT2),
    .INIT_CNT1(INIT_CNT1)
  ) u_inv (
    .clk          (clk),
    .reset        (reset),
    .i_restock    (w_restock_ok),
    .i_restock_sel(restock_sel),
    .i_restock_cnt(restock_cnt),
    .i_dec        (w_ack),
    .i_dec_sel    (r_coin_sel),
    .o_cnt5       (cnt5),
    .o_cnt2       (cnt2),
    .o_cnt1       (cnt1)
  );

  // Greedy pick; remaining==0 falls through every branch and reports nothing to pay
  always_comb begin
    w_sel_ok = 1'b1;
    w_sel    = COIN_1;
    if (r_remaining >= VAL_5 && cnt5 != '0)
      w_sel = COIN_5;
    else if (r_remaining >= VAL_2 && cnt2 != '0)
      w_sel = COIN_2;
    else if (r_remaining >= VAL_1 && cnt1 != '0)
      w_sel = COIN_1;
    else
      w_sel_ok = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_SELECT;
      ST_SELECT: w_next = w_sel_ok ? ST_REQ : ST_DONE;
      ST_REQ:    if (coin_ack) w_next = ST_SELECT;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    coin_req = (r_state == ST_REQ);
    busy     = (r_state != ST_IDLE);
    done     = (r_state == ST_DONE);
    short    = (r_state == ST_DONE) && (r_remaining != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_remaining <= '0;
      r_paid      <= '0;
      r_coin_sel  <= COIN_1;
    end else begin
      if (w_start_ok) begin
        r_remaining <= amount;
        r_paid      <= '0;
      end
      if (r_state == ST_SELECT && w_sel_ok)
        r_coin_sel <= w_sel;
      if (w_ack) begin
        r_remaining <= r_remaining - w_value;
        r_paid      <= r_paid + w_value;
      end
    end
  end

  assign coin_sel  = r_coin_sel;
  assign remaining = r_remaining;
  assign paid      = r_paid;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with a greedy payout scoreboard and hopper model.
module tb_change_dispenser;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] amount;
  logic       coin_req;
  logic [1:0] coin_sel;
  logic       coin_ack;
  logic       restock;
  logic [1:0] restock_sel;
  logic [7:0] restock_cnt;
  logic       busy;
  logic       done;
  logic       short;
  logic [7:0] remaining;
  logic [7:0] paid;
  logic [7:0] cnt5;
  logic [7:0] cnt2;
  logic [7:0] cnt1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] paid;
    logic [7:0] rem;
    logic       shrt;
  } res_t;

  logic [1:0] exp_coin[$];
  res_t       exp_res[$];
  int         m_cnt[3];

  change_dispenser #(
    .INV_W(8), .INIT_CNT5(20), .INIT_CNT2(20), .INIT_CNT1(20)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .amount(amount),
    .coin_req(coin_req), .coin_sel(coin_sel), .coin_ack(coin_ack),
    .restock(restock), .restock_sel(restock_sel), .restock_cnt(restock_cnt),
    .busy(busy), .done(done), .short(short),
    .remaining(remaining), .paid(paid),
    .cnt5(cnt5), .cnt2(cnt2), .cnt1(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int coin_val(input int d);
    return (d == 2) ? 5 : (d == 1) ? 2 : 1;
  endfunction

  task automatic model_reset();
    m_cnt[0] = 20; m_cnt[1] = 20; m_cnt[2] = 20;
    exp_coin.delete();
    exp_res.delete();
  endtask

  task automatic model_restock(input int sel, input int n);
    m_cnt[sel] = (m_cnt[sel] + n > 255) ? 255 : m_cnt[sel] + n;
  endtask

  task automatic model_payout(input int amt);
    int  rem;
    bit  found;
    res_t r;
    rem = amt;
    do begin
      found = 1'b0;
      for (int d = 2; d >= 0; d--) begin
        if (!found && rem >= coin_val(d) && m_cnt[d] > 0) begin
          found = 1'b1;
          exp_coin.push_back(2'(d));
          rem = rem - coin_val(d);
          m_cnt[d] = m_cnt[d] - 1;
        end
      end
    end while (found);
    r.paid = 8'(amt - rem);
    r.rem  = 8'(rem);
    r.shrt = (rem != 0);
    exp_res.push_back(r);
  endtask

  task automatic chk_inv(input string tag);
    chk({tag, "_cnt5"}, 32'(cnt5), 32'(m_cnt[2]));
    chk({tag, "_cnt2"}, 32'(cnt2), 32'(m_cnt[1]));
    chk({tag, "_cnt1"}, 32'(cnt1), 32'(m_cnt[0]));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   32'(coin_req),  0);
    chk({tag, "_done"},  32'(done),      0);
    chk({tag, "_short"}, 32'(short),     0);
    chk({tag, "_busy"},  32'(busy),      0);
    chk({tag, "_rem"},   32'(remaining), 0);
    chk({tag, "_paid"},  32'(paid),      0);
    chk({tag, "_sel"},   32'(coin_sel),  0);
    chk({tag, "_cnt5"},  32'(cnt5),      20);
    chk({tag, "_cnt2"},  32'(cnt2),      20);
    chk({tag, "_cnt1"},  32'(cnt1),      20);
  endtask

  // Drive one start pulse (optionally with a simultaneous restock) and load the scoreboard.
  task automatic start_pay(input int amt, input bit rs, input int rs_sel, input int rs_cnt);
    if (rs) model_restock(rs_sel, rs_cnt);
    model_payout(amt);
    amount      = 8'(amt);
    start       = 1'b1;
    restock     = rs;
    restock_sel = 2'(rs_sel);
    restock_cnt = 8'(rs_cnt);
    step();
    start   = 1'b0;
    restock = 1'b0;
  endtask

  // Hopper model: acks each request after dly cycles, checks coins and the final result.
  task automatic service(input string tag, input int dly, output int ncyc, output int nreq);
    bit         fin;
    int         budget;
    logic [1:0] c;
    res_t       r;
    fin = 1'b0; budget = 0; ncyc = 0; nreq = 0;
    while (!fin) begin
      if (budget > 2000) begin
        chk({tag, "_timeout"}, 1, 0);
        fin = 1'b1;
      end else if (done) begin
        if (exp_res.size() == 0) begin
          chk({tag, "_unexpected_done"}, 1, 0);
        end else begin
          r = exp_res.pop_front();
          chk({tag, "_paid"},  32'(paid),      32'(r.paid));
          chk({tag, "_rem"},   32'(remaining), 32'(r.rem));
          chk({tag, "_short"}, 32'(short),     32'(r.shrt));
          chk({tag, "_busy_done"}, 32'(busy), 1);
        end
        chk({tag, "_coins_left"}, 32'(exp_coin.size()), 0);
        fin = 1'b1;
      end else if (coin_req) begin
        nreq++;
        if (exp_coin.size() == 0) begin
          chk({tag, "_extra_coin"}, 32'(coin_sel), 99);
          c = coin_sel;
        end else begin
          c = exp_coin.pop_front();
          chk({tag, "_sel"}, 32'(coin_sel), 32'(c));
        end
        for (int k = 0; k < dly; k++) begin
          step();
          ncyc++;
          chk({tag, "_hold_req"}, 32'(coin_req), 1);
          chk({tag, "_hold_sel"}, 32'(coin_sel), 32'(c));
        end
        coin_ack = 1'b1;
        step();
        ncyc++;
        coin_ack = 1'b0;
      end else begin
        step();
        ncyc++;
      end
      budget++;
    end
    step();
    chk({tag, "_done_pulse"}, 32'(done), 0);
    chk({tag, "_idle"},       32'(busy), 0);
  endtask

  initial begin
    int ncyc;
    int nreq;
    int wait_cnt;

    reset = 1'b1; start = 1'b0; amount = '0; coin_ack = 1'b0;
    restock = 1'b0; restock_sel = '0; restock_cnt = '0;
    model_reset();
    repeat (2) step();
    chk_reset("por");
    reset = 1'b0;
    step();

    // Basic greedy payout of 13: 5,5,2,1
    start_pay(13, 0, 0, 0);
    service("p13", 0, ncyc, nreq);
    chk("p13_nreq", 32'(nreq), 4);
    chk("p13_cnt5", 32'(cnt5), 18);
    chk("p13_cnt2", 32'(cnt2), 19);
    chk("p13_cnt1", 32'(cnt1), 19);

    // Zero amount: done on the second sample after start, no coins
    start_pay(0, 0, 0, 0);
    service("p0", 0, ncyc, nreq);
    chk("p0_latency", 32'(ncyc), 1);
    chk("p0_nreq", 32'(nreq), 0);
    chk_inv("p0");

    // Slow hopper
    start_pay(5, 0, 0, 0);
    service("p5slow", 5, ncyc, nreq);
    chk("p5slow_nreq", 32'(nreq), 1);

    // Spurious ack while idle
    coin_ack = 1'b1;
    step();
    coin_ack = 1'b0;
    step();
    chk("spur_busy", 32'(busy), 0);
    chk("spur_req", 32'(coin_req), 0);
    chk("spur_paid", 32'(paid), 5);
    chk("spur_rem", 32'(remaining), 0);
    chk_inv("spur");

    // Reset in the middle of a handshake
    amount = 8'd12;
    start  = 1'b1;
    step();
    start = 1'b0;
    wait_cnt = 0;
    while (!coin_req && wait_cnt < 10) begin
      step();
      wait_cnt++;
    end
    chk("r12_req_seen", 32'(coin_req), 1);
    #2 reset = 1'b1;
    #1 chk_reset("r12");
    model_reset();
    step();
    reset = 1'b0;
    step();

    // Shortfall: drain to 0/0/0, restock 2-unit and 1-unit by one each, then ask for 6
    start_pay(100, 0, 0, 0);
    service("drain5", 0, ncyc, nreq);
    start_pay(255, 0, 0, 0);
    service("drain_all", 0, ncyc, nreq);
    chk("drain_all_paid", 32'(paid), 60);
    restock = 1'b1; restock_sel = 2'd1; restock_cnt = 8'd1;
    model_restock(1, 1);
    step();
    restock_sel = 2'd0;
    model_restock(0, 1);
    step();
    restock = 1'b0;
    chk_inv("rs_short");
    start_pay(6, 0, 0, 0);
    service("short6", 0, ncyc, nreq);
    chk("short6_nreq", 32'(nreq), 2);
    chk("short6_paid", 32'(paid), 3);
    chk("short6_rem", 32'(remaining), 3);

    // Fresh inventory, saturating restock
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    step();
    restock = 1'b1; restock_sel = 2'd0; restock_cnt = 8'd250;
    model_restock(0, 250);
    step();
    restock = 1'b0;
    chk("sat_cnt1", 32'(cnt1), 255);
    chk_inv("sat");

    // Restock while busy is ignored
    start_pay(1, 0, 0, 0);
    restock = 1'b1; restock_sel = 2'd2; restock_cnt = 8'd3;
    step();
    restock = 1'b0;
    service("busy_rs", 0, ncyc, nreq);
    chk("busy_rs_cnt5", 32'(cnt5), 20);
    chk_inv("busy_rs");

    // Empty the 5-unit bin, then start together with a one-coin restock of it
    start_pay(100, 0, 0, 0);
    service("drain5b", 0, ncyc, nreq);
    chk("drain5b_cnt5", 32'(cnt5), 0);
    start_pay(5, 1, 2, 1);
    service("st_rs", 0, ncyc, nreq);
    chk("st_rs_nreq", 32'(nreq), 1);
    chk("st_rs_paid", 32'(paid), 5);
    chk_inv("st_rs");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
